// File: rtl/stim_sequencer.sv
// stim_sequencer: table-driven stimulus and LED checker for the n-bit cpu.
// Optional build macro STIM_SEQ_WAIT_MATCH_EN ends each step early on the first LED match during HOLD.
module stim_sequencer #(
   parameter int unsigned n           = 8,
   parameter int unsigned SW_W        = 9,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned RST_CYCLES  = 2,
   parameter int unsigned HOLD_CYCLES = 8,
   localparam int unsigned AW         = $clog2(DEPTH)
) (
   input  logic            Clock,
   input  logic            nReset,
   input  logic            LoadEn,
   input  logic [AW-1:0]   LoadAddr,
   input  logic [SW_W-1:0] LoadSw,
   input  logic [n-1:0]    LoadExp,
   input  logic            Start,
   input  logic [AW:0]     StepCount,
   input  logic [n-1:0]    LEDs,
   output logic [SW_W-1:0] Switches,
   output logic            CpuReset,
   output logic            Busy,
   output logic            Done,
   output logic            Pass,
   output logic [AW:0]     ErrCount,
   output logic [AW-1:0]   FailStep
);

   localparam int unsigned CW  = AW + 1;
   localparam int unsigned RCW = $clog2(RST_CYCLES + 1);
   localparam int unsigned HCW = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_APPLY,
      S_HOLD,
      S_CHECK,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [SW_W-1:0] tbl_sw  [DEPTH];
   logic [n-1:0]    tbl_exp [DEPTH];

   logic [SW_W-1:0] sw_q, sw_d;
   logic            cpu_reset_q, cpu_reset_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [CW-1:0]   err_q, err_d;
   logic [AW-1:0]   fail_q, fail_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   count_q, count_d;
   logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
   logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;

   logic [SW_W-1:0] cur_sw;
   logic [n-1:0]    cur_exp;
   logic            last_step;
   logic            miss;
   logic            accept_start;

   // Table has no reset so loaded contents survive nReset.
   always_ff @(posedge Clock) begin
      if (LoadEn && !busy_q) begin
         tbl_sw[LoadAddr]  <= LoadSw;
         tbl_exp[LoadAddr] <= LoadExp;
      end
   end

   assign cur_sw       = tbl_sw[idx_q];
   assign cur_exp      = tbl_exp[idx_q];
   assign last_step    = ({1'b0, idx_q} == (count_q - CW'(1)));
   assign accept_start = Start && !busy_q;

`ifdef STIM_SEQ_WAIT_MATCH_EN
   logic matched_q, matched_d;
   logic led_match;

   assign led_match = (LEDs == cur_exp);
   // A step fails only if the whole HOLD window passed without a match.
   assign miss      = !matched_q;
`else
   assign miss      = (LEDs != cur_exp);
`endif

   // State and datapath registers.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q     <= S_IDLE;
         sw_q        <= '0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_q       <= '0;
         fail_q      <= '0;
         idx_q       <= '0;
         count_q     <= '0;
         rst_cnt_q   <= '0;
         hold_cnt_q  <= '0;
`ifdef STIM_SEQ_WAIT_MATCH_EN
         matched_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sw_q        <= sw_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_q       <= err_d;
         fail_q      <= fail_d;
         idx_q       <= idx_d;
         count_q     <= count_d;
         rst_cnt_q   <= rst_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
`ifdef STIM_SEQ_WAIT_MATCH_EN
         matched_q   <= matched_d;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: if (accept_start) state_d = S_RST;
         S_RST:          if (rst_cnt_q == '0) state_d = S_APPLY;
         S_APPLY:        state_d = (count_q == '0) ? S_DONE : S_HOLD;
`ifdef STIM_SEQ_WAIT_MATCH_EN
         S_HOLD:         if (led_match || hold_cnt_q == '0) state_d = S_CHECK;
`else
         S_HOLD:         if (hold_cnt_q == '0) state_d = S_CHECK;
`endif
         S_CHECK:        state_d = last_step ? S_DONE : S_APPLY;
         default:        state_d = S_IDLE;
      endcase
   end

   // Next values of outputs and counters.
   always_comb begin
      sw_d        = sw_q;
      cpu_reset_d = cpu_reset_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      err_d       = err_q;
      fail_d      = fail_q;
      idx_d       = idx_q;
      count_d     = count_q;
      rst_cnt_d   = rst_cnt_q;
      hold_cnt_d  = hold_cnt_q;
`ifdef STIM_SEQ_WAIT_MATCH_EN
      matched_d   = matched_q;
`endif
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_IDLE) cpu_reset_d = 1'b1;
            if (accept_start) begin
               count_d     = StepCount;
               cpu_reset_d = 1'b1;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               err_d       = '0;
               fail_d      = '0;
               idx_d       = '0;
               rst_cnt_d   = RCW'(RST_CYCLES - 1);
            end
         end
         S_RST: begin
            idx_d = '0;
            if (rst_cnt_q != '0) rst_cnt_d = rst_cnt_q - RCW'(1);
         end
         S_APPLY: begin
            cpu_reset_d = 1'b0;
            // Zero-length run: nothing to apply, finish with a clean pass.
            if (count_q == '0) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               pass_d = (err_q == '0);
            end else begin
               sw_d       = cur_sw;
               hold_cnt_d = HCW'(HOLD_CYCLES - 1);
`ifdef STIM_SEQ_WAIT_MATCH_EN
               matched_d  = 1'b0;
`endif
            end
         end
         S_HOLD: begin
            if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - HCW'(1);
`ifdef STIM_SEQ_WAIT_MATCH_EN
            if (led_match) matched_d = 1'b1;
`endif
         end
         S_CHECK: begin
            if (miss) begin
               if (err_q == '0) fail_d = idx_q;
               if (err_q != '1) err_d = err_q + CW'(1);
            end
            if (last_step) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               pass_d = (err_d == '0);
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         default: ;
      endcase
   end

   assign Switches = sw_q;
   assign CpuReset = cpu_reset_q;
   assign Busy     = busy_q;
   assign Done     = done_q;
   assign Pass     = pass_q;
   assign ErrCount = err_q;
   assign FailStep = fail_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Bench for stim_sequencer: table model predicts each run, results queued and compared when Done rises.
module tb_stim_sequencer;

   localparam int R = 2;
   localparam int H = 8;

   logic       Clock, nReset, LoadEn, Start;
   logic [3:0] LoadAddr;
   logic [8:0] LoadSw;
   logic [7:0] LoadExp, LEDs;
   logic [4:0] StepCount, ErrCount;
   logic [8:0] Switches;
   logic       CpuReset, Busy, Done, Pass;
   logic [3:0] FailStep;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic       pass;
      logic [4:0] err;
      logic [3:0] fs;
      logic [8:0] sw;
   } res_t;

   res_t sb[$];
   logic [8:0] m_sw  [16];
   logic [7:0] m_exp [16];
   logic [8:0] m_last_sw = '0;

   // cpu model: LEDs follow Switches, optionally one cycle late.
   logic       led_mode = 1'b0;
   logic [7:0] led_d1 = '0;
   always @(posedge Clock) led_d1 <= Switches[7:0];
   assign LEDs = led_mode ? led_d1 : Switches[7:0];

   stim_sequencer dut (
      .Clock(Clock), .nReset(nReset), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
      .LoadSw(LoadSw), .LoadExp(LoadExp), .Start(Start), .StepCount(StepCount),
      .LEDs(LEDs), .Switches(Switches), .CpuReset(CpuReset), .Busy(Busy),
      .Done(Done), .Pass(Pass), .ErrCount(ErrCount), .FailStep(FailStep)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic int step_len(input bit mode, input logic [8:0] sw, input logic [7:0] ex);
`ifdef STIM_SEQ_WAIT_MATCH_EN
      if (sw[7:0] == ex) return mode ? 4 : 3;
`endif
      return H + 2;
   endfunction

   task automatic load_entry(input int a, input logic [8:0] sw, input logic [7:0] ex);
      @(negedge Clock);
      LoadEn = 1'b1; LoadAddr = 4'(a); LoadSw = sw; LoadExp = ex;
      @(negedge Clock);
      LoadEn = 1'b0;
      m_sw[a] = sw; m_exp[a] = ex;
   endtask

   task automatic push_exp(input int cnt, input bit mode);
      res_t e;
      e.err = '0; e.fs = '0; e.sw = m_last_sw;
      e.cyc = (cnt == 0) ? R + 1 : R;
      for (int j = 0; j < cnt; j++) begin
         if (m_sw[j][7:0] != m_exp[j]) begin
            if (e.err == 5'd0) e.fs = 4'(j);
            if (e.err != 5'h1f) e.err = e.err + 5'd1;
         end
         e.cyc += step_len(mode, m_sw[j], m_exp[j]);
         e.sw = m_sw[j];
      end
      e.pass = (e.err == 5'd0);
      m_last_sw = e.sw;
      sb.push_back(e);
   endtask

   task automatic do_run(input int cnt, input bit mode, input bit ld, input int la,
                         input logic [8:0] lsw, input logic [7:0] lex, output res_t o);
      if (ld) begin m_sw[la] = lsw; m_exp[la] = lex; end
      push_exp(cnt, mode);
      @(negedge Clock);
      Start = 1'b1; StepCount = 5'(cnt);
      if (ld) begin LoadEn = 1'b1; LoadAddr = 4'(la); LoadSw = lsw; LoadExp = lex; end
      @(posedge Clock); #1;
      Start = 1'b0; LoadEn = 1'b0;
      checks++;
      if (Busy !== 1'b1) begin errors++; $display("FAIL busy_at_start got=%b want=1", Busy); end
      o.cyc = 0;
      while (Done !== 1'b1 && o.cyc < 2000) begin @(posedge Clock); #1; o.cyc++; end
      if (Done !== 1'b1) begin
         checks++; errors++;
         $display("FAIL run_timeout got=Done=%b want=Done=1 within 2000 cycles", Done);
      end
      o.pass = Pass; o.err = ErrCount; o.fs = FailStep; o.sw = Switches;
   endtask

   task automatic test_reset;
      nReset = 1'b0; Start = 1'b0; LoadEn = 1'b0; LoadAddr = '0; LoadSw = '0; LoadExp = '0;
      StepCount = '0;
      repeat (3) @(posedge Clock);
      #1;
      checks++; if (CpuReset !== 1'b1) begin errors++; $display("FAIL reset_cpureset got=%b want=1", CpuReset); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", Busy); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", Done); end
      checks++; if (Pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b want=0", Pass); end
      checks++; if (Switches !== 9'h000) begin errors++; $display("FAIL reset_switches got=%h want=000", Switches); end
      checks++; if (ErrCount !== 5'd0) begin errors++; $display("FAIL reset_errcount got=%0d want=0", ErrCount); end
      checks++; if (FailStep !== 4'd0) begin errors++; $display("FAIL reset_failstep got=%0d want=0", FailStep); end
      @(negedge Clock); nReset = 1'b1;
      repeat (2) @(posedge Clock);
      #1;
      checks++; if (CpuReset !== 1'b1) begin errors++; $display("FAIL idle_cpureset got=%b want=1", CpuReset); end
   endtask

   task automatic test_pass_run;
      res_t o, e;
      load_entry(0, 9'h001, 8'h01);
      load_entry(1, 9'h002, 8'h02);
      load_entry(2, 9'h0FF, 8'hFF);
      do_run(3, 1'b0, 1'b0, 0, '0, '0, o);
      e = sb.pop_front();
      checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL pass_run_cycles got=%0d want=%0d", o.cyc, e.cyc); end
      checks++; if (o.pass !== e.pass) begin errors++; $display("FAIL pass_run_pass got=%b want=%b", o.pass, e.pass); end
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL pass_run_err got=%0d want=%0d", o.err, e.err); end
      checks++; if (o.sw !== e.sw) begin errors++; $display("FAIL pass_run_sw got=%h want=%h", o.sw, e.sw); end
      checks++; if (CpuReset !== 1'b0) begin errors++; $display("FAIL pass_run_cpureset got=%b want=0", CpuReset); end
   endtask

   task automatic test_fail_run;
      res_t o, e;
      load_entry(1, 9'h002, 8'h05);
      do_run(3, 1'b0, 1'b0, 0, '0, '0, o);
      e = sb.pop_front();
      checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL fail_run_cycles got=%0d want=%0d", o.cyc, e.cyc); end
      checks++; if (o.pass !== e.pass) begin errors++; $display("FAIL fail_run_pass got=%b want=%b", o.pass, e.pass); end
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL fail_run_err got=%0d want=%0d", o.err, e.err); end
      checks++; if (o.fs !== e.fs) begin errors++; $display("FAIL fail_run_failstep got=%0d want=%0d", o.fs, e.fs); end
      checks++; if (o.sw !== e.sw) begin errors++; $display("FAIL fail_run_sw got=%h want=%h", o.sw, e.sw); end
   endtask

   task automatic test_edge_cases;
      res_t obs[$];
      res_t o, e;
      do_run(0, 1'b0, 1'b0, 0, '0, '0, o); obs.push_back(o);
      for (int j = 0; j < 16; j++) begin
         logic [8:0] v;
         v = 9'(j * 17) | ((j % 2 == 1) ? 9'h100 : 9'h000);
         load_entry(j, v, v[7:0]);
      end
      do_run(16, 1'b0, 1'b0, 0, '0, '0, o); obs.push_back(o);
      for (int j = 0; j < 16; j++) load_entry(j, m_sw[j], ~m_sw[j][7:0]);
      do_run(16, 1'b0, 1'b0, 0, '0, '0, o); obs.push_back(o);
      load_entry(0, 9'h001, 8'h01);
      load_entry(1, 9'h002, 8'h05);
      load_entry(2, 9'h0FF, 8'hFF);
      for (int r = 0; r < 3; r++) begin
         o = obs.pop_front(); e = sb.pop_front();
         checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL edge%0d_cycles got=%0d want=%0d", r, o.cyc, e.cyc); end
         checks++; if (o.pass !== e.pass) begin errors++; $display("FAIL edge%0d_pass got=%b want=%b", r, o.pass, e.pass); end
         checks++; if (o.err !== e.err) begin errors++; $display("FAIL edge%0d_err got=%0d want=%0d", r, o.err, e.err); end
         checks++; if (o.fs !== e.fs) begin errors++; $display("FAIL edge%0d_failstep got=%0d want=%0d", r, o.fs, e.fs); end
         checks++; if (o.sw !== e.sw) begin errors++; $display("FAIL edge%0d_sw got=%h want=%h", r, o.sw, e.sw); end
      end
   endtask

   task automatic test_ignored_inputs;
      res_t obs[$];
      res_t o, e;
      fork
         begin
            repeat (6) @(posedge Clock);
            #2;
            Start = 1'b1; StepCount = 5'd5;
            LoadEn = 1'b1; LoadAddr = 4'd0; LoadSw = 9'h155; LoadExp = 8'h00;
            @(posedge Clock); #1;
            Start = 1'b0; LoadEn = 1'b0;
         end
      join_none
      do_run(3, 1'b0, 1'b0, 0, '0, '0, o); obs.push_back(o);
      do_run(3, 1'b0, 1'b0, 0, '0, '0, o); obs.push_back(o);
      do_run(1, 1'b0, 1'b1, 0, 9'h0AA, 8'hAB, o); obs.push_back(o);
      for (int r = 0; r < 3; r++) begin
         o = obs.pop_front(); e = sb.pop_front();
         checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL ign%0d_cycles got=%0d want=%0d", r, o.cyc, e.cyc); end
         checks++; if (o.err !== e.err) begin errors++; $display("FAIL ign%0d_err got=%0d want=%0d", r, o.err, e.err); end
         checks++; if (o.fs !== e.fs) begin errors++; $display("FAIL ign%0d_failstep got=%0d want=%0d", r, o.fs, e.fs); end
         checks++; if (o.sw !== e.sw) begin errors++; $display("FAIL ign%0d_sw got=%h want=%h", r, o.sw, e.sw); end
      end
   endtask

   task automatic test_reset_mid_run;
      res_t o, e;
      @(negedge Clock);
      Start = 1'b1; StepCount = 5'd3;
      @(posedge Clock); #1;
      Start = 1'b0;
      repeat (R + 3) @(posedge Clock);
      #1;
      checks++; if (Switches !== m_sw[0]) begin errors++; $display("FAIL mid_applied_sw got=%h want=%h", Switches, m_sw[0]); end
      #1 nReset = 1'b0;
      #1;
      checks++; if (CpuReset !== 1'b1) begin errors++; $display("FAIL mid_cpureset got=%b want=1", CpuReset); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b want=0", Busy); end
      checks++; if (Switches !== 9'h000) begin errors++; $display("FAIL mid_switches got=%h want=000", Switches); end
      checks++; if (ErrCount !== 5'd0) begin errors++; $display("FAIL mid_errcount got=%0d want=0", ErrCount); end
      @(negedge Clock); nReset = 1'b1;
      m_last_sw = '0;
      do_run(3, 1'b0, 1'b0, 0, '0, '0, o);
      e = sb.pop_front();
      checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL rerun_cycles got=%0d want=%0d", o.cyc, e.cyc); end
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL rerun_err got=%0d want=%0d", o.err, e.err); end
      checks++; if (o.fs !== e.fs) begin errors++; $display("FAIL rerun_failstep got=%0d want=%0d", o.fs, e.fs); end
      checks++; if (o.pass !== e.pass) begin errors++; $display("FAIL rerun_pass got=%b want=%b", o.pass, e.pass); end
   endtask

`ifdef STIM_SEQ_WAIT_MATCH_EN
   task automatic test_wait_match;
      res_t o, e;
      load_entry(0, 9'h011, 8'h11);
      load_entry(1, 9'h022, 8'h33);
      led_mode = 1'b1;
      do_run(2, 1'b1, 1'b0, 0, '0, '0, o);
      led_mode = 1'b0;
      e = sb.pop_front();
      checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL wait_cycles got=%0d want=%0d", o.cyc, e.cyc); end
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL wait_err got=%0d want=%0d", o.err, e.err); end
      checks++; if (o.fs !== e.fs) begin errors++; $display("FAIL wait_failstep got=%0d want=%0d", o.fs, e.fs); end
   endtask
`endif

   initial begin
      test_reset();
      test_pass_run();
      test_fail_run();
      test_edge_cases();
      test_ignored_inputs();
      test_reset_mid_run();
`ifdef STIM_SEQ_WAIT_MATCH_EN
      test_wait_match();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
